// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Writeback driver for the 32x32 register file write port. It merges an ALU
//   result stream and a MEM (load / long-latency) result stream into a single
//   registered write port. It also keeps a pending-write scoreboard so decode
//   can stall on registers that have outstanding long-latency writes.
//
//   Optional build macro REGFILE_WB_SKID_EN:
//     When it is defined, a one-entry skid register captures each MEM result.
//     The skid entry, not the mem_* inputs, then competes for the write port,
//     and mem_ready_o only reflects whether the skid is empty.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   alu_valid_i/rd_i/val_i        ALU result handshake in
//   alu_ready_o                   ALU result accepted this cycle
//   mem_valid_i/rd_i/val_i        MEM result handshake in
//   mem_ready_o                   MEM result accepted this cycle
//   mark_i, mark_rd_i             long-latency op issued: set busy[mark_rd_i]
//   rf_we_o/rd_sel_o/w_val_o      registered register-file write port
//   busy_o                        scoreboard; bit n = write to xn pending
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_val_i,
    output logic            alu_ready_o,
    input  logic            mem_valid_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_val_i,
    output logic            mem_ready_o,
    input  logic            mark_i,
    input  logic [4:0]      mark_rd_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_sel_o,
    output logic [XLEN-1:0] rf_w_val_o,
    output logic [31:0]     busy_o
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic            r_we;
    logic [4:0]      r_rd_sel;
    logic [XLEN-1:0] r_w_val;
    logic [31:0]     r_busy;
    logic [3:0]      r_starve_cnt;

    logic            w_mem_pend;
    logic [4:0]      w_mem_rd;
    logic [XLEN-1:0] w_mem_val;
    logic            w_force_mem;
    logic            w_grant_alu;
    logic            w_grant_mem;
    logic [31:0]     w_busy_nxt;

`ifdef REGFILE_WB_SKID_EN
    logic            r_skid_vld;
    logic [4:0]      r_skid_rd;
    logic [XLEN-1:0] r_skid_val;

    assign w_mem_pend  = r_skid_vld;
    assign w_mem_rd    = r_skid_rd;
    assign w_mem_val   = r_skid_val;
    assign mem_ready_o = ~r_skid_vld;

    // Capture happens only when the skid is empty. A grant happens only when
    // it is full. So the two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_vld <= 1'b0;
            r_skid_rd  <= '0;
            r_skid_val <= '0;
        end else if (mem_valid_i && !r_skid_vld) begin
            r_skid_vld <= 1'b1;
            r_skid_rd  <= mem_rd_i;
            r_skid_val <= mem_val_i;
        end else if (w_grant_mem) begin
            r_skid_vld <= 1'b0;
        end
    end
`else
    assign w_mem_pend  = mem_valid_i;
    assign w_mem_rd    = mem_rd_i;
    assign w_mem_val   = mem_val_i;
    assign mem_ready_o = w_grant_mem;
`endif

    // ALU has priority unless MEM has waited STARVE_MAX cycles.
    assign w_force_mem = w_mem_pend && (r_starve_cnt == C_STARVE_MAX);
    assign w_grant_alu = alu_valid_i && !w_force_mem;
    assign w_grant_mem = w_mem_pend && !w_grant_alu;
    assign alu_ready_o = w_grant_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_mem_pend || w_grant_mem) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != C_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // A result for x0 completes its handshake but never drives the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_rd_sel <= '0;
            r_w_val  <= '0;
        end else if (w_grant_alu) begin
            r_we <= (alu_rd_i != 5'd0);
            if (alu_rd_i != 5'd0) begin
                r_rd_sel <= alu_rd_i;
                r_w_val  <= alu_val_i;
            end
        end else if (w_grant_mem) begin
            r_we <= (w_mem_rd != 5'd0);
            if (w_mem_rd != 5'd0) begin
                r_rd_sel <= w_mem_rd;
                r_w_val  <= w_mem_val;
            end
        end else begin
            r_we <= 1'b0;
        end
    end

    // Clear is applied before set, so a same-cycle mark of the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant_mem && (w_mem_rd != 5'd0)) begin
            w_busy_nxt[w_mem_rd] = 1'b0;
        end
        if (mark_i && (mark_rd_i != 5'd0)) begin
            w_busy_nxt[mark_rd_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_we_o     = r_we;
    assign rf_rd_sel_o = r_rd_sel;
    assign rf_w_val_o  = r_w_val;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_val_i;
    logic        alu_ready_o;
    logic        mem_valid_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_val_i;
    logic        mem_ready_o;
    logic        mark_i;
    logic [4:0]  mark_rd_i;
    logic        rf_we_o;
    logic [4:0]  rf_rd_sel_o;
    logic [31:0] rf_w_val_o;
    logic [31:0] busy_o;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_val_i   (alu_val_i),
        .alu_ready_o (alu_ready_o),
        .mem_valid_i (mem_valid_i),
        .mem_rd_i    (mem_rd_i),
        .mem_val_i   (mem_val_i),
        .mem_ready_o (mem_ready_o),
        .mark_i      (mark_i),
        .mark_rd_i   (mark_rd_i),
        .rf_we_o     (rf_we_o),
        .rf_rd_sel_o (rf_rd_sel_o),
        .rf_w_val_o  (rf_w_val_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd5;
        alu_val_i   = 32'h0000_0055;
        mem_valid_i = 1'b0;
        mem_rd_i    = 5'd0;
        mem_val_i   = 32'h0;
        mark_i      = 1'b0;
        mark_rd_i   = 5'd0;
        tick();
        tick();
        chk("rst_we",   {31'b0, rf_we_o}, 32'd0);
        chk("rst_sel",  {27'b0, rf_rd_sel_o}, 32'd0);
        chk("rst_val",  rf_w_val_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);

        // ALU request for x5 is still held; it is written one edge after release.
        rst_n = 1'b1;
        tick();
        chk("first_we",  {31'b0, rf_we_o}, 32'd1);
        chk("first_sel", {27'b0, rf_rd_sel_o}, 32'd5);
        chk("first_val", rf_w_val_o, 32'h55);

        alu_rd_i  = 5'd3;
        alu_val_i = 32'hDEAD_BEEF;
        #1;
        chk("alu_ready", {31'b0, alu_ready_o}, 32'd1);
        tick();
        alu_valid_i = 1'b0;
        chk("alu_we",  {31'b0, rf_we_o}, 32'd1);
        chk("alu_sel", {27'b0, rf_rd_sel_o}, 32'd3);
        chk("alu_val", rf_w_val_o, 32'hDEAD_BEEF);
        tick();
        chk("alu_we_drop", {31'b0, rf_we_o}, 32'd0);
        chk("alu_sel_hold", {27'b0, rf_rd_sel_o}, 32'd3);

        // Back-to-back ALU writes leave no bubble.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd2;
        alu_val_i   = 32'h2222;
        tick();
        chk("b2b_we0", {31'b0, rf_we_o}, 32'd1);
        alu_rd_i  = 5'd4;
        alu_val_i = 32'h4444;
        tick();
        chk("b2b_we1",  {31'b0, rf_we_o}, 32'd1);
        chk("b2b_sel1", {27'b0, rf_rd_sel_o}, 32'd4);
        alu_valid_i = 1'b0;
        tick();

`ifndef REGFILE_WB_SKID_EN
        // Starvation: the ALU wins 3 cycles, then MEM is forced in on the 4th.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd1;
        alu_val_i   = 32'hA1;
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'd7;
        mem_val_i   = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stv_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
            chk("stv_mem_rdy", {31'b0, mem_ready_o}, 32'd0);
            tick();
            chk("stv_alu_sel", {27'b0, rf_rd_sel_o}, 32'd1);
        end
        #1;
        chk("stv_force_alu", {31'b0, alu_ready_o}, 32'd0);
        chk("stv_force_mem", {31'b0, mem_ready_o}, 32'd1);
        tick();
        mem_valid_i = 1'b0;
        chk("stv_mem_we",  {31'b0, rf_we_o}, 32'd1);
        chk("stv_mem_sel", {27'b0, rf_rd_sel_o}, 32'd7);
        chk("stv_mem_val", rf_w_val_o, 32'h77);
        #1;
        chk("stv_alu_back", {31'b0, alu_ready_o}, 32'd1);
        tick();
        alu_valid_i = 1'b0;
        tick();

        // Scoreboard set, same-cycle set/clear, and later clear.
        mark_i    = 1'b1;
        mark_rd_i = 5'd9;
        tick();
        chk("sb_set", busy_o, 32'h0000_0200);
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'd9;
        mem_val_i   = 32'h99;
        #1;
        chk("sb_mem_rdy", {31'b0, mem_ready_o}, 32'd1);
        tick();
        mark_i = 1'b0;
        chk("sb_set_wins", busy_o, 32'h0000_0200);
        chk("sb_we9", {27'b0, rf_rd_sel_o}, 32'd9);
        mem_val_i = 32'h98;
        tick();
        mem_valid_i = 1'b0;
        chk("sb_clear", busy_o, 32'd0);

        // A mark for x0 never sets a busy bit.
        mark_i    = 1'b1;
        mark_rd_i = 5'd0;
        tick();
        chk("sb_x0", busy_o, 32'd0);
        mark_rd_i = 5'd4;
        tick();
        mark_i = 1'b0;
        chk("sb_x4", busy_o, 32'h10);

        // A MEM result for x0 is accepted but produces no write.
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'd0;
        mem_val_i   = 32'hBAD;
        #1;
        chk("rd0_rdy", {31'b0, mem_ready_o}, 32'd1);
        tick();
        mem_valid_i = 1'b0;
        chk("rd0_we",   {31'b0, rf_we_o}, 32'd0);
        chk("rd0_busy", busy_o, 32'h10);
        chk("rd0_val_hold", rf_w_val_o, 32'h98);
`else
        // Skid: MEM is captured in one cycle, then is written after the starvation grant.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd1;
        alu_val_i   = 32'hA1;
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'd7;
        mem_val_i   = 32'h77;
        mark_i      = 1'b1;
        mark_rd_i   = 5'd7;
        #1;
        chk("sk_mem_rdy", {31'b0, mem_ready_o}, 32'd1);
        tick();
        mem_valid_i = 1'b0;
        mem_val_i   = 32'h0;
        mark_i      = 1'b0;
        chk("sk_busy", busy_o, 32'h80);
        #1;
        chk("sk_full", {31'b0, mem_ready_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sk_alu_rdy", {31'b0, alu_ready_o}, 32'd1);
            tick();
            chk("sk_alu_sel", {27'b0, rf_rd_sel_o}, 32'd1);
        end
        chk("sk_force_alu", {31'b0, alu_ready_o}, 32'd0);
        tick();
        chk("sk_we",   {31'b0, rf_we_o}, 32'd1);
        chk("sk_sel",  {27'b0, rf_rd_sel_o}, 32'd7);
        chk("sk_val",  rf_w_val_o, 32'h77);
        chk("sk_clr",  busy_o, 32'd0);
        chk("sk_empty", {31'b0, mem_ready_o}, 32'd1);
        alu_valid_i = 1'b0;
        tick();
        mark_i    = 1'b1;
        mark_rd_i = 5'd4;
        tick();
        mark_i = 1'b0;
`endif

        // Reset in the middle of a write drops it at once and clears the scoreboard.
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd6;
        alu_val_i   = 32'h66;
        tick();
        chk("mid_we_pre", {31'b0, rf_we_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we",   {31'b0, rf_we_o}, 32'd0);
        chk("mid_busy", busy_o, 32'd0);
        alu_valid_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
